dmem_mmio: RTL and testbench

DMEM_MMIO -- requirements
Module: dmem_mmio

---
 rtl/dmem_mmio.sv | 163 ++++++++++++++++
 tb/tb_dmem_mmio.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data memory with a small memory-mapped peripheral block for a single-cycle core.
// RAM occupies the low MEM_WORDS*4 bytes, and a GPIO output register plus a
// compare/match timer sit at 0xFFFF_FF00..0xFFFF_FF0C.
// Loads are combinational. Stores commit on the rising edge of clk.
module dmem_mmio #(
    parameter int MEM_WORDS = 64,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       aluout,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int AW = $clog2(MEM_WORDS);

    // Word addresses (byte address >> 2) of the peripheral registers
    localparam logic [29:0] A_GPIO   = 30'h3FFF_FFC0;
    localparam logic [29:0] A_TCOUNT = 30'h3FFF_FFC1;
    localparam logic [29:0] A_TCMP   = 30'h3FFF_FFC2;
    localparam logic [29:0] A_TCTRL  = 30'h3FFF_FFC3;

    // Storage
    logic [31:0]       r_mem [MEM_WORDS];
    logic [GPIO_W-1:0] r_gpio;
    logic [31:0]       r_tcount;
    logic [31:0]       r_tcmp;
    logic              r_en;
    logic              r_autoclr;
    logic              r_flag;
    logic              r_irq;

    // Decode
    logic [29:0]       w_waddr;
    logic [AW-1:0]     w_word_idx;
    logic              w_sel_ram;
    logic              w_sel_gpio;
    logic              w_sel_tcount;
    logic              w_sel_tcmp;
    logic              w_sel_tctrl;
    logic              w_match;
    logic [31:0]       w_tcount_next;
    logic              w_flag_next;
    logic [31:0]       w_gpio_ext;
    logic [31:0]       w_tctrl_rd;

    // Byte-lane bits are never decoded; access is whole-word only
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, aluout[1:0]};

    assign w_waddr      = aluout[31:2];
    assign w_word_idx   = aluout[AW+1:2];
    assign w_sel_ram    = (aluout[31:AW+2] == '0);
    assign w_sel_gpio   = (w_waddr == A_GPIO);
    assign w_sel_tcount = (w_waddr == A_TCOUNT);
    assign w_sel_tcmp   = (w_waddr == A_TCMP);
    assign w_sel_tctrl  = (w_waddr == A_TCTRL);

    // The match is judged on the pre-edge count, compare value and enable.
    // A store landing on the same edge therefore cannot mask a match.
    assign w_match = r_en && (r_tcount == r_tcmp);

    // Next timer count: a software write wins, then auto-clear on match, then increment
    always_comb begin
        w_tcount_next = r_tcount;
        if (memwrite && w_sel_tcount) begin
            w_tcount_next = writedata;
        end else if (r_en) begin
            if (w_match && r_autoclr) begin
                w_tcount_next = 32'd0;
            end else begin
                w_tcount_next = r_tcount + 32'd1;
            end
        end
    end

    // Next FLAG: a match sets it, and that takes priority over a write-1-to-clear
    always_comb begin
        w_flag_next = r_flag;
        if (w_match) begin
            w_flag_next = 1'b1;
        end else if (memwrite && w_sel_tctrl && writedata[2]) begin
            w_flag_next = 1'b0;
        end
    end

    // RAM write port. The RAM is never reset, and stores are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (memwrite && reset && w_sel_ram) begin
            r_mem[w_word_idx] <= writedata;
        end
    end

    // GPIO output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gpio <= '0;
        end else if (memwrite && w_sel_gpio) begin
            r_gpio <= writedata[GPIO_W-1:0];
        end
    end

    // Timer count and compare registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcount <= 32'd0;
            r_tcmp   <= 32'd0;
        end else begin
            r_tcount <= w_tcount_next;
            if (memwrite && w_sel_tcmp) begin
                r_tcmp <= writedata;
            end
        end
    end

    // Timer control bits and the status flag. The IRQ is loaded with the same next value as FLAG, so it never lags FLAG.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en      <= 1'b0;
            r_autoclr <= 1'b0;
            r_flag    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (memwrite && w_sel_tctrl) begin
                r_en      <= writedata[0];
                r_autoclr <= writedata[1];
            end
            r_flag <= w_flag_next;
            r_irq  <= w_flag_next;
        end
    end

    // Zero-extended views of the narrow registers for the read mux
    always_comb begin
        w_gpio_ext             = 32'd0;
        w_gpio_ext[GPIO_W-1:0] = r_gpio;
        w_tctrl_rd             = {29'd0, r_flag, r_autoclr, r_en};
    end

    // Combinational load path; any unmapped address reads as zero
    always_comb begin
        readdata = 32'd0;
        if (w_sel_ram) begin
            readdata = r_mem[w_word_idx];
        end else if (w_sel_gpio) begin
            readdata = w_gpio_ext;
        end else if (w_sel_tcount) begin
            readdata = r_tcount;
        end else if (w_sel_tcmp) begin
            readdata = r_tcmp;
        end else if (w_sel_tctrl) begin
            readdata = w_tctrl_rd;
        end
    end

    assign gpio_out  = r_gpio;
    assign timer_irq = r_irq;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed testbench for dmem_mmio.
// Expected values are hand-computed from the register map and the timer rules.
module tb_dmem_mmio;

    localparam logic [31:0] GPIO_A   = 32'hFFFF_FF00;
    localparam logic [31:0] TCOUNT_A = 32'hFFFF_FF04;
    localparam logic [31:0] TCMP_A   = 32'hFFFF_FF08;
    localparam logic [31:0] TCTRL_A  = 32'hFFFF_FF0C;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    dmem_mmio #(.MEM_WORDS(64), .GPIO_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        $display("check %-14s got %08h expected %08h", tag, got, exp);
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present a load address away from the edge and compare the combinational result
    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        memwrite = 1'b0;
        aluout   = addr;
        #1;
        check(tag, readdata, exp);
    endtask

    // One store cycle. The task returns 1 time unit after the committing edge.
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        aluout    = addr;
        writedata = data;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_seq [8];

    initial begin
        exp_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
        reset     = 1'b0;
        memwrite  = 1'b0;
        aluout    = 32'd0;
        writedata = 32'd0;

        // Reset state
        #12;
        check("rst_gpio", {24'd0, gpio_out}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        rd_check("rst_tcount", TCOUNT_A, 32'd0);
        rd_check("rst_tctrl", TCTRL_A, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // RAM store/load and byte-offset aliasing
        store(32'h0000_0010, 32'hDEAD_BEEF);
        rd_check("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_check("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
        store(32'h0000_0014, 32'h1234_5678);
        rd_check("ram_14", 32'h0000_0014, 32'h1234_5678);
        rd_check("ram_10_keep", 32'h0000_0010, 32'hDEAD_BEEF);
        store(32'h0000_00FC, 32'hCAFE_F00D);
        rd_check("ram_top", 32'h0000_00FC, 32'hCAFE_F00D);
        rd_check("ram_past_end", 32'h0000_0100, 32'd0);

        // GPIO
        store(GPIO_A, 32'h0000_01A5);
        check("gpio_out", {24'd0, gpio_out}, 32'h0000_00A5);
        rd_check("gpio_rd", GPIO_A, 32'h0000_00A5);

        // Unmapped store leaves everything alone
        store(32'h0000_0000, 32'h1111_1111);
        store(TCMP_A, 32'd5);
        store(32'h8000_0000, 32'hFFFF_FFFF);
        store(32'hFFFF_FF10, 32'hFFFF_FFFF);
        check("unm_gpio", {24'd0, gpio_out}, 32'h0000_00A5);
        rd_check("unm_rd", 32'h8000_0000, 32'd0);
        rd_check("unm_rd2", 32'hFFFF_FF10, 32'd0);
        rd_check("unm_tcmp", TCMP_A, 32'd5);
        rd_check("unm_ram0", 32'h0000_0000, 32'h1111_1111);
        rd_check("unm_tcount", TCOUNT_A, 32'd0);
        rd_check("unm_tctrl", TCTRL_A, 32'd0);

        // Auto-clear match: count 0..5, then 0, and FLAG rises on the 5->0 edge
        store(TCTRL_A, 32'h0000_0003);
        for (int i = 0; i < 8; i++) begin
            rd_check($sformatf("seq_cnt%0d", i), TCOUNT_A, exp_seq[i]);
            check($sformatf("seq_irq%0d", i), {31'd0, timer_irq}, (i >= 6) ? 32'd1 : 32'd0);
            tick();
        end

        // W1C without a match clears FLAG and stops the timer
        store(TCTRL_A, 32'h0000_0004);
        check("w1c_irq", {31'd0, timer_irq}, 32'd0);
        rd_check("w1c_tctrl", TCTRL_A, 32'd0);

        // W1C in the same cycle as a match: set wins
        store(TCOUNT_A, 32'd3);
        store(TCTRL_A, 32'h0000_0001);
        rd_check("col_cnt3", TCOUNT_A, 32'd3);
        tick();
        tick();
        rd_check("col_cnt5", TCOUNT_A, 32'd5);
        store(TCTRL_A, 32'h0000_0005);
        check("col_irq", {31'd0, timer_irq}, 32'd1);
        rd_check("col_tctrl", TCTRL_A, 32'h0000_0005);
        rd_check("col_cnt6", TCOUNT_A, 32'd6);

        // A TCOUNT store beats the increment
        store(TCOUNT_A, 32'h0000_0100);
        rd_check("wr_cnt", TCOUNT_A, 32'h0000_0100);
        tick();
        rd_check("wr_cnt_inc", TCOUNT_A, 32'h0000_0101);

        // Wrap from 0xFFFF_FFFF to 0
        store(TCOUNT_A, 32'hFFFF_FFFF);
        rd_check("wrap_max", TCOUNT_A, 32'hFFFF_FFFF);
        tick();
        rd_check("wrap_zero", TCOUNT_A, 32'd0);
        check("pre_rst_irq", {31'd0, timer_irq}, 32'd1);

        // Asynchronous reset mid-count, with no clock edge in between
        reset = 1'b0;
        #1;
        check("arst_irq", {31'd0, timer_irq}, 32'd0);
        check("arst_gpio", {24'd0, gpio_out}, 32'd0);
        rd_check("arst_tcount", TCOUNT_A, 32'd0);
        rd_check("arst_tcmp", TCMP_A, 32'd0);
        store(GPIO_A, 32'h0000_00FF);
        check("rst_store", {24'd0, gpio_out}, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        rd_check("post_tcount", TCOUNT_A, 32'd0);
        rd_check("post_tctrl", TCTRL_A, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
